sent_tx_frame_gen: RTL and testbench
====================================

// Module: sent_tx_frame_gen
// PURPOSE
//  SENT (SAE J2716) transmit frame generator; consumer of the TX data register stage.
//  - Captures data_f1/data_f2 on each done pulse and splits them into data nibbles per load_bit.
//  - Computes the CRC-4 and drives the single-wire SENT line: sync, status, data, CRC, optional pause.
//  - Runs on clk_tx. One-deep shadow buffer so the next frame follows back-to-back.
// PARAMETERS
//  TICK_DIV           3    clk_tx cycles per SENT tick (>=2; e.g. 120 for 3us at 40MHz)
//  LOW_TICKS          5    low-phase length of every symbol, in ticks (4..11)
//  PAUSE_FRAME_TICKS  282  total frame length incl. pause (only with SENT_TX_PAUSE_PULSE_EN)
// PORTS
//  clk_tx         in   1   transmit clock
//  reset_n_tx     in   1   asynchronous reset, active low
//  load_bit       in   3   frame format; sampled at capture
//  data_f1        in   16  fast-channel-1 data from the data register stage
//  data_f2        in   12  fast-channel-2 data from the data register stage
//  done           in   1   1-cycle strobe: data_f1/data_f2 valid this cycle
//  status_nibble  in   4   status/comm nibble; sampled with data
//  sent_out       out  1   SENT line; idle high
//  busy           out  1   frame in progress (state != IDLE)
//  frame_done     out  1   1-cycle pulse on the last cycle of each frame
//  overrun        out  1   1-cycle pulse: done arrived while shadow already full
// BEHAVIOUR
//  - Reset (async, reset_n_tx=0): sent_out=1; busy, frame_done and overrun=0; shadow empty;
//    state=IDLE; prescaler and tick counters=0.
//  - Capture: on done, {load_bit,data,status} go to the shadow.
//    load_bit=000 at capture: ignore done, no shadow write.
//  - Format: 001, 110, 111 -> 6 data nibbles; 24-bit word sent MSN first.
//    001={f1[11:0],f2[11:0]}; 110={f1[13:0],f2[9:0]}; 111={f1[15:0],f2[7:0]}.
//    010..101 -> 3 nibbles from f1[11:0], MSN first.
//  - Overrun: done with shadow full and not consumed this cycle -> overwrite shadow, pulse overrun.
//  - Start: in IDLE the prescaler is held at 0. The cycle after a shadow write: enter SYNC,
//    sent_out=0, shadow moved to the active frame registers and freed.
//  - FSM: IDLE -> SYNC(56 ticks) -> STATUS(12+s) -> DATA(12+n, per nibble) -> CRC(12+c) ->
//    [PAUSE] -> SYNC if shadow valid, else IDLE.
//    Every symbol: LOW_TICKS ticks low, then high for the remainder.
//  - Tick: 1 tick = TICK_DIV clk_tx cycles. Symbol boundaries fall on tick boundaries only.
//  - CRC-4 (x^4+x^3+x^2+1) over data nibbles only, status excluded:
//    crc=4'h5; per nibble n: crc=T[crc]^n; final crc=T[crc].
//    T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
//  - frame_done: pulses on the last cycle of the CRC symbol, or of PAUSE when enabled.
//    Transition to the next SYNC (or IDLE) occurs on the following cycle.
//  - done coinciding with the frame-end cycle: the new data is written to the shadow and
//    starts the next frame without an IDLE gap.
//  - load_bit or data changing mid-frame has no effect on the active frame.
//  - Reset mid-frame: line returns high immediately; the partial frame is discarded.
// CONFIGURATION
//  - SENT_TX_PAUSE_PULSE_EN defined: PAUSE symbol appended after CRC.
//    Length = PAUSE_FRAME_TICKS - (ticks of sync..CRC), clamped to a minimum of 12 ticks.
//    Same low/high shape as any symbol. Frames are constant length.
//  - SENT_TX_PAUSE_PULSE_EN undefined: no PAUSE state; CRC goes directly to SYNC/IDLE;
//    PAUSE_FRAME_TICKS is unused.
// STRUCTURE
//  - Package sent_pkg holds: SYNC_TICKS=56, NIBBLE_BASE_TICKS=12, CRC_SEED=4'h5, the CRC table T,
//    the state enum, function num_nibbles(load_bit), and function crc4(nibbles,count).
//  - Sub-module sent_tick_gen: TICK_DIV prescaler with sync clear.
//    Outputs a 1-cycle tick strobe; shared with the RX side.
// TESTING
//  1. load_bit=010, f1=12'h123, status=0, single done.
//     -> data nibbles 1,2,3, CRC=0; frame = 56+12+13+14+15+12 = 122 ticks; then IDLE with
//     sent_out=1. With PAUSE enabled: pause 160 ticks, 282 total.
//  2. load_bit=111, f1=16'hABCD, f2=8'hEF.
//     -> nibbles A,B,C,D,E,F; CRC equals crc4() of the package; every low phase is
//     LOW_TICKS*TICK_DIV cycles.
//  3. done pulsed again mid-frame 1 -> frame 2 SYNC falls the cycle after frame_done;
//     no IDLE cycle; overrun stays 0.
//  4. Three done pulses within one frame -> one overrun pulse; frame 2 carries the third
//     data set.
//  5. reset_n_tx low during DATA -> sent_out=1 asynchronously; after release: IDLE,
//     busy=0, shadow empty.
//  6. done with load_bit=000 -> no frame, busy stays 0; load_bit=001 with f1=f2=0 ->
//     six 12-tick data nibbles.

Source files
------------

// File: rtl/sent_pkg.sv
// Shared SENT definitions: symbol timing constants, CRC-4 table and helpers, frame FSM states.
// Used by the transmit frame generator (and the tick prescaler on the RX side).
package sent_pkg;

    localparam int         SYNC_TICKS        = 56;
    localparam int         NIBBLE_BASE_TICKS = 12;
    localparam logic [3:0] CRC_SEED          = 4'h5;
    // T[i] lives in bits [4*i+3:4*i]; T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}
    localparam logic [63:0] CRC_TABLE        = 64'h582F_B6C1_493E_A7D0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_STATUS, ST_DATA, ST_CRC, ST_PAUSE
    } state_t;

    typedef struct packed {
        logic [23:0] word;    // data nibbles, first-sent nibble in [23:20]
        logic [2:0]  count;   // 3 or 6 nibbles
        logic [3:0]  status;
    } frame_t;

    function automatic logic [3:0] crc_lookup(input logic [3:0] idx);
        return CRC_TABLE[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [2:0] num_nibbles(input logic [2:0] load_bit);
        case (load_bit)
            3'b001, 3'b110, 3'b111: return 3'd6;
            default:                return 3'd3;
        endcase
    endfunction

    function automatic logic [23:0] build_word(input logic [2:0] load_bit,
                                               input logic [15:0] f1,
                                               input logic [11:0] f2);
        case (load_bit)
            3'b001:  return {f1[11:0], f2};
            3'b110:  return {f1[13:0], f2[9:0]};
            3'b111:  return {f1, f2[7:0]};
            default: return {f1[11:0], 12'h000};
        endcase
    endfunction

    function automatic logic [3:0] crc4(input logic [23:0] nibbles, input logic [2:0] count);
        logic [3:0] crc;
        crc = CRC_SEED;
        for (int i = 0; i < 6; i++) begin
            if (i < 32'(count)) crc = crc_lookup(crc) ^ nibbles[(5 - i) * 4 +: 4];
        end
        return crc_lookup(crc);
    endfunction

endpackage

// File: rtl/sent_tick_gen.sv
// SENT tick prescaler: one-cycle tick every TICK_DIV clocks, held at zero while clear is high.
module sent_tick_gen #(
    parameter int TICK_DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cnt <= '0;
        else if (clear || cnt == LAST)  cnt <= '0;
        else                            cnt <= cnt + CW'(1);
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT (SAE J2716) transmit frame generator with a one-deep shadow buffer.
// Define SENT_TX_PAUSE_PULSE_EN to append a pause symbol for constant-length frames.
module sent_tx_frame_gen
    import sent_pkg::*;
#(
    parameter int TICK_DIV          = 3,
    parameter int LOW_TICKS         = 5,
    parameter int PAUSE_FRAME_TICKS = 282
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic [2:0]  load_bit,
    input  logic [15:0] data_f1,
    input  logic [11:0] data_f2,
    input  logic        done,
    input  logic [3:0]  status_nibble,
    output logic        sent_out,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);
    // Wide enough for the sync symbol and for the longest pause either build can produce
    localparam int LEN_W = $clog2(PAUSE_FRAME_TICKS + 64);

    state_t           state, state_nxt;
    logic             tick, sym_end, frame_end, consume, cap, load;
    logic [LEN_W-1:0] tcnt, sym_len;
    frame_t           sh, cap_frame, load_frame;
    logic             sh_valid, overrun_q;
    logic [23:0]      act_word;
    logic [3:0]       act_status, act_crc, load_crc;
    logic [2:0]       nib_left;
`ifdef SENT_TX_PAUSE_PULSE_EN
    logic [LEN_W-1:0] act_pause, pause_len;
    int               body_ticks;
`endif

    sent_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk_tx),
        .rst_n (reset_n_tx),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    // A captured done can bypass the shadow when the FSM is ready to take a frame this cycle
    always_comb begin
        cap              = done && (load_bit != 3'b000);
        cap_frame.word   = build_word(load_bit, data_f1, data_f2);
        cap_frame.count  = num_nibbles(load_bit);
        cap_frame.status = status_nibble;
        load_frame       = sh_valid ? sh : cap_frame;
        load_crc         = crc4(load_frame.word, load_frame.count);
    end

`ifdef SENT_TX_PAUSE_PULSE_EN
    always_comb begin
        body_ticks = SYNC_TICKS + 2 * NIBBLE_BASE_TICKS + 32'(load_frame.status) + 32'(load_crc);
        for (int i = 0; i < 6; i++) begin
            if (i < 32'(load_frame.count))
                body_ticks = body_ticks + NIBBLE_BASE_TICKS + 32'(load_frame.word[(5 - i) * 4 +: 4]);
        end
        pause_len = (PAUSE_FRAME_TICKS - body_ticks < NIBBLE_BASE_TICKS) ?
                    LEN_W'(NIBBLE_BASE_TICKS) : LEN_W'(PAUSE_FRAME_TICKS - body_ticks);
    end
`endif

    always_comb begin
        sym_len = '0;
        case (state)
            ST_SYNC:   sym_len = LEN_W'(SYNC_TICKS);
            ST_STATUS: sym_len = LEN_W'(NIBBLE_BASE_TICKS) + LEN_W'(act_status);
            ST_DATA:   sym_len = LEN_W'(NIBBLE_BASE_TICKS) + LEN_W'(act_word[23:20]);
            ST_CRC:    sym_len = LEN_W'(NIBBLE_BASE_TICKS) + LEN_W'(act_crc);
`ifdef SENT_TX_PAUSE_PULSE_EN
            ST_PAUSE:  sym_len = act_pause;
`endif
            default:   sym_len = '0;
        endcase
        sym_end = tick && (tcnt == sym_len - LEN_W'(1));
`ifdef SENT_TX_PAUSE_PULSE_EN
        frame_end = sym_end && (state == ST_PAUSE);
`else
        frame_end = sym_end && (state == ST_CRC);
`endif
        consume = (state == ST_IDLE) || frame_end;
        load    = consume && (sh_valid || cap);
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load) state_nxt = ST_SYNC;
            ST_SYNC:   if (sym_end) state_nxt = ST_STATUS;
            ST_STATUS: if (sym_end) state_nxt = ST_DATA;
            ST_DATA:   if (sym_end && nib_left == 3'd0) state_nxt = ST_CRC;
`ifdef SENT_TX_PAUSE_PULSE_EN
            ST_CRC:    if (sym_end) state_nxt = ST_PAUSE;
            ST_PAUSE:  if (sym_end) state_nxt = load ? ST_SYNC : ST_IDLE;
`else
            ST_CRC:    if (sym_end) state_nxt = load ? ST_SYNC : ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sent_out   = 1'b1;
        busy       = 1'b0;
        frame_done = 1'b0;
        if (state != ST_IDLE) begin
            busy       = 1'b1;
            sent_out   = (tcnt >= LEN_W'(LOW_TICKS));
            frame_done = frame_end;
        end
    end

    assign overrun = overrun_q;

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            tcnt       <= '0;
            sh         <= '0;
            sh_valid   <= 1'b0;
            overrun_q  <= 1'b0;
            act_word   <= '0;
            act_status <= '0;
            act_crc    <= '0;
            nib_left   <= '0;
`ifdef SENT_TX_PAUSE_PULSE_EN
            act_pause  <= '0;
`endif
        end else begin
            overrun_q <= cap && sh_valid && !consume;
            if (state == ST_IDLE || sym_end) tcnt <= '0;
            else if (tick)                   tcnt <= tcnt + LEN_W'(1);
            if (load) begin
                act_word   <= load_frame.word;
                act_status <= load_frame.status;
                act_crc    <= load_crc;
                nib_left   <= load_frame.count - 3'd1;
`ifdef SENT_TX_PAUSE_PULSE_EN
                act_pause  <= pause_len;
`endif
                sh         <= cap_frame;
                sh_valid   <= sh_valid && cap;
            end else begin
                if (state == ST_DATA && sym_end) begin
                    act_word <= {act_word[19:0], 4'h0};
                    nib_left <= nib_left - 3'd1;
                end
                if (cap) begin
                    sh       <= cap_frame;
                    sh_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Directed bench for sent_tx_frame_gen: symbol lengths and low phases are checked against a
// queue of expected tick counts built from each accepted done strobe.
module tb_sent_tx_frame_gen;
    localparam int TICK_DIV          = 3;
    localparam int LOW_TICKS         = 5;
    localparam int PAUSE_FRAME_TICKS = 282;

    logic        clk_tx = 1'b0;
    logic        reset_n_tx = 1'b0;
    logic [2:0]  load_bit = '0;
    logic [15:0] data_f1 = '0;
    logic [11:0] data_f2 = '0;
    logic        done = 1'b0;
    logic [3:0]  status_nibble = '0;
    logic        sent_out, busy, frame_done, overrun;

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] exp_q[$];

    bit          model_busy = 0;
    bit          sh_valid = 0;
    logic [2:0]  sh_lb;
    logic [15:0] sh_f1;
    logic [11:0] sh_f2;
    logic [3:0]  sh_st;
    int          exp_ovr = 0;
    int          ovr_seen = 0;
    int          base_ovr;

    bit mon_en = 1, in_sym = 0, prev_line = 1, prev_fd = 0, exp_next = 0;
    int sym_cyc = 0, low_cyc = 0;

    sent_tx_frame_gen #(
        .TICK_DIV(TICK_DIV), .LOW_TICKS(LOW_TICKS), .PAUSE_FRAME_TICKS(PAUSE_FRAME_TICKS)
    ) dut (
        .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .load_bit(load_bit), .data_f1(data_f1),
        .data_f2(data_f2), .done(done), .status_nibble(status_nibble), .sent_out(sent_out),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // CRC table entry by long division of v*x^4 by x^4+x^3+x^2+1
    function automatic logic [3:0] tb_tbl(input logic [3:0] v);
        logic [7:0] r;
        r = {v, 4'h0};
        for (int b = 7; b >= 4; b--) if (r[b]) r = r ^ (8'h1D << (b - 4));
        return r[3:0];
    endfunction

    task automatic push_frame(input logic [2:0] lb, input logic [15:0] f1,
                              input logic [11:0] f2, input logic [3:0] st);
        logic [23:0] w;
        logic [3:0]  nb, crc;
        int          n, sum;
        case (lb)
            3'b001:  w = {f1[11:0], f2};
            3'b110:  w = {f1[13:0], f2[9:0]};
            3'b111:  w = {f1, f2[7:0]};
            default: w = {f1[11:0], 12'h000};
        endcase
        n = (lb == 3'b001 || lb == 3'b110 || lb == 3'b111) ? 6 : 3;
        exp_q.push_back(16'd56);
        exp_q.push_back(16'(12 + st));
        sum = 56 + 12 + st;
        crc = 4'h5;
        for (int i = 0; i < n; i++) begin
            nb = w[23 - 4 * i -: 4];
            exp_q.push_back(16'(12 + nb));
            sum = sum + 12 + nb;
            crc = tb_tbl(crc) ^ nb;
        end
        crc = tb_tbl(crc);
        exp_q.push_back(16'(12 + crc));
        sum = sum + 12 + crc;
`ifdef SENT_TX_PAUSE_PULSE_EN
        exp_q.push_back(16'((PAUSE_FRAME_TICKS - sum < 12) ? 12 : PAUSE_FRAME_TICKS - sum));
`endif
    endtask

    task automatic send(input logic [2:0] lb, input logic [15:0] f1,
                        input logic [11:0] f2, input logic [3:0] st);
        @(posedge clk_tx); #1;
        load_bit = lb; data_f1 = f1; data_f2 = f2; status_nibble = st; done = 1'b1;
        if (lb != 3'b000) begin
            if (!model_busy) begin
                push_frame(lb, f1, f2, st);
                model_busy = 1;
            end else begin
                if (sh_valid) exp_ovr++;
                sh_valid = 1; sh_lb = lb; sh_f1 = f1; sh_f2 = f2; sh_st = st;
            end
        end
        @(posedge clk_tx); #1;
        done = 1'b0;
        load_bit = 3'($urandom); data_f1 = 16'($urandom); data_f2 = 12'($urandom);
        status_nibble = 4'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_tx);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || model_busy || exp_q.size() != 0) && k < 4000) begin
            @(negedge clk_tx);
            k++;
        end
        check(tag, 32'(k < 4000), 1);
        @(negedge clk_tx);
        check({tag, "_line"}, 32'(sent_out), 1);
    endtask

    task automatic close_sym();
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check("sym_extra", sym_cyc, 0);
        end else begin
            e = exp_q.pop_front();
            check("sym_len", sym_cyc, 32'(e) * TICK_DIV);
            check("sym_low", low_cyc, LOW_TICKS * TICK_DIV);
        end
    endtask

    // Line monitor: measures every symbol from falling edge to next falling edge or idle
    always @(negedge clk_tx) begin
        if (overrun) ovr_seen++;
        if (!mon_en) begin
            in_sym = 0; prev_line = 1; prev_fd = 0;
        end else begin
            if (prev_fd) begin
                check("gap_busy", 32'(busy), 32'(exp_next));
                check("gap_line", 32'(sent_out), 32'(!exp_next));
            end
            if (prev_line && !sent_out) begin
                if (in_sym) close_sym();
                in_sym = 1; sym_cyc = 1; low_cyc = 1;
            end else if (in_sym && !busy) begin
                close_sym();
                in_sym = 0;
            end else if (in_sym) begin
                sym_cyc++;
                if (!sent_out) low_cyc++;
            end
            prev_fd = frame_done;
            if (frame_done) begin
                exp_next = sh_valid;
                if (sh_valid) begin
                    push_frame(sh_lb, sh_f1, sh_f2, sh_st);
                    sh_valid = 0;
                end else begin
                    model_busy = 0;
                end
            end
            prev_line = sent_out;
        end
    end

    initial begin
        #12;
        check("rst_line", 32'(sent_out), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        @(posedge clk_tx); #1;
        reset_n_tx = 1'b1;
        cycles(5);
        check("idle_busy", 32'(busy), 0);

        // 3-nibble frame, nibbles 1,2,3 with CRC 0
        send(3'b010, 16'h0123, 12'h000, 4'h0);
        wait_idle("t1_done");

        // 6-nibble frame, nibbles A..F
        send(3'b111, 16'hABCD, 12'h0EF, 4'h5);
        wait_idle("t2_done");

        // second done mid-frame chains without an idle cycle
        base_ovr = ovr_seen;
        send(3'b001, 16'h0456, 12'h789, 4'h3);
        cycles(50);
        send(3'b110, 16'h3FFF, 12'h3A5, 4'h9);
        wait_idle("t3_done");
        check("t3_overrun", ovr_seen - base_ovr, 0);

        // three dones in one frame: one overrun, third data set sent
        base_ovr = ovr_seen;
        send(3'b011, 16'h0FED, 12'h000, 4'h1);
        cycles(40);
        send(3'b001, 16'h0111, 12'h111, 4'h2);
        cycles(40);
        send(3'b001, 16'h0F0F, 12'hA5A, 4'hC);
        wait_idle("t4_done");
        check("t4_overrun", ovr_seen - base_ovr, 1);

        // reset during the data nibbles
        base_ovr = ovr_seen;
        send(3'b010, 16'h0123, 12'h000, 4'h0);
        cycles(230);
        check("t5_pre_busy", 32'(busy), 1);
        mon_en = 0;
        reset_n_tx = 1'b0;
        #1;
        check("t5_rst_line", 32'(sent_out), 1);
        check("t5_rst_busy", 32'(busy), 0);
        exp_q.delete();
        model_busy = 0;
        sh_valid = 0;
        cycles(3);
        reset_n_tx = 1'b1;
        mon_en = 1;
        cycles(40);
        check("t5_post_busy", 32'(busy), 0);
        check("t5_post_line", 32'(sent_out), 1);
        check("t5_overrun", ovr_seen - base_ovr, 0);

        // load_bit 000 ignored, then all-zero 6-nibble frame
        send(3'b000, 16'h1234, 12'h567, 4'h0);
        cycles(20);
        check("t6_ignored_busy", 32'(busy), 0);
        send(3'b001, 16'h0000, 12'h000, 4'h0);
        wait_idle("t6_done");

        // random frames with random spacing
        for (int i = 0; i < 4; i++) begin
            send(3'($urandom_range(7, 1)), 16'($urandom), 12'($urandom), 4'($urandom_range(15, 0)));
            cycles($urandom_range(60, 250));
        end
        wait_idle("rand_done");
        check("rand_overrun", ovr_seen, exp_ovr);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
